// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-side signals of the stall/flush controller.
interface hazard_control_unit_if #(parameter int CNT_W = 32) ();
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic id_uses_rs1;
    logic id_uses_rs2;
    logic [4:0] ex_rd;
    logic ex_dmem_read;
    logic imem_read;
    logic imem_resp;
    logic dmem_req;
    logic dmem_resp;
    logic br_taken;
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic stall_mem_wb;
    logic bubble_id_ex;
    logic flush_if_id;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_dmem_read,
               imem_read, imem_resp, dmem_req, dmem_resp, br_taken,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
               bubble_id_ex, flush_if_id, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_dmem_read,
               imem_read, imem_resp, dmem_req, dmem_resp, br_taken,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb,
               bubble_id_ex, flush_if_id, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use bubble, memory freeze and branch flush sequencing with counters.
module hazard_control_unit #(parameter int CNT_W = 32) (
    input logic clk,
    input logic rst,
    hazard_control_unit_if.slave hz
);
    typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;
    state_t state, state_nx;
    logic flush_pend, flush_pend_nx;
    logic stall_all, stall_lu, bubble, flush;
    logic mem_wait, lu_hit;
    logic [CNT_W-1:0] stall_q, flush_q;
    assign mem_wait = (hz.imem_read & ~hz.imem_resp) | (hz.dmem_req & ~hz.dmem_resp);
    assign lu_hit = hz.ex_dmem_read & (hz.ex_rd != 5'd0) &
                    ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                     (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    always_comb begin
        state_nx = state;
        flush_pend_nx = flush_pend;
        stall_all = 1'b0;
        stall_lu = 1'b0;
        bubble = 1'b0;
        flush = 1'b0;
        case (state)
            RUN: begin
                if (mem_wait) begin
                    stall_all = 1'b1;
                    state_nx = MEM_WAIT;
                    flush_pend_nx = hz.br_taken;
                end else if (hz.br_taken) begin
                    flush = 1'b1;
                    bubble = 1'b1;
                end else if (lu_hit) begin
                    stall_lu = 1'b1;
                    bubble = 1'b1;
                    state_nx = LU_BUBBLE;
                end
            end
            LU_BUBBLE: begin
                stall_all = mem_wait;
                state_nx = mem_wait ? MEM_WAIT : RUN;
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    stall_all = 1'b1;
                end else if (flush_pend) begin
                    flush = 1'b1;
                    bubble = 1'b1;
                    flush_pend_nx = 1'b0;
                    state_nx = RUN;
                end else if (lu_hit) begin
                    stall_lu = 1'b1;
                    bubble = 1'b1;
                    state_nx = LU_BUBBLE;
                end else begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end
    // Outputs are gated by reset so an in-flight stall drops the moment rst falls.
    assign hz.stall_pc = rst & (stall_all | stall_lu);
    assign hz.stall_if_id = rst & (stall_all | stall_lu);
    assign hz.stall_id_ex = rst & stall_all;
    assign hz.stall_ex_mem = rst & stall_all;
    assign hz.stall_mem_wb = rst & stall_all;
    assign hz.bubble_id_ex = rst & bubble;
    assign hz.flush_if_id = rst & flush;
    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            flush_pend <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state <= state_nx;
            flush_pend <= flush_pend_nx;
            if (hz.stall_pc && !(&stall_q)) stall_q <= stall_q + 1'b1;
            if (hz.flush_if_id && !(&flush_q)) flush_q <= flush_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed checks of the stall/flush controller with narrow counters.
module tb_hazard_control_unit;
    localparam int CNT_W = 3;
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] ALL = 7'b1111100;
    localparam logic [6:0] LU = 7'b1100010;
    localparam logic [6:0] FL = 7'b0000011;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [6:0] o;
    hazard_control_unit_if #(.CNT_W(CNT_W)) b ();
    hazard_control_unit #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .hz(b));
    always #5 clk = ~clk;
    assign o = {b.stall_pc, b.stall_if_id, b.stall_id_ex, b.stall_ex_mem, b.stall_mem_wb,
                b.bubble_id_ex, b.flush_if_id};
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic outs(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, o}, {25'd0, exp});
    endtask
    task automatic cnts(input string tag, input int s, input int f);
        chk({tag, "_stall_cnt"}, 32'(b.stall_cnt), s);
        chk({tag, "_flush_cnt"}, 32'(b.flush_cnt), f);
    endtask
    task automatic clr();
        b.id_rs1 = 0; b.id_rs2 = 0; b.id_uses_rs1 = 0; b.id_uses_rs2 = 0;
        b.ex_rd = 0; b.ex_dmem_read = 0; b.imem_read = 0; b.imem_resp = 0;
        b.dmem_req = 0; b.dmem_resp = 0; b.br_taken = 0;
    endtask
    task automatic lw_use();
        b.ex_dmem_read = 1; b.ex_rd = 5; b.id_rs1 = 5; b.id_uses_rs1 = 1;
        b.id_rs2 = 1; b.id_uses_rs2 = 1;
    endtask
    initial begin
        clr();
        #2 outs("reset_outs", NONE);
        cnts("reset", 0, 0);
        @(negedge clk); rst = 1;
        lw_use();
        #1 outs("lu_stall", LU);
        @(negedge clk); #1 outs("lu_single_bubble", NONE);
        @(negedge clk); clr();
        #1 outs("lu_after", NONE);
        cnts("lu", 1, 0);
        @(negedge clk); b.ex_dmem_read = 1; b.id_uses_rs1 = 1;
        #1 outs("x0_load", NONE);
        @(negedge clk); clr(); b.dmem_req = 1;
        #1 outs("dmem_w1", ALL);
        @(negedge clk); #1 outs("dmem_w2", ALL);
        @(negedge clk); #1 outs("dmem_w3", ALL);
        @(negedge clk); #1 outs("dmem_w4", ALL);
        @(negedge clk); b.dmem_resp = 1;
        #1 outs("dmem_resp", NONE);
        @(negedge clk); clr();
        #1 outs("dmem_after", NONE);
        cnts("dmem", 5, 0);
        @(negedge clk); b.imem_read = 1; b.br_taken = 1;
        #1 outs("br_imem_w1", ALL);
        @(negedge clk); #1 outs("br_imem_w2", ALL);
        @(negedge clk); b.imem_resp = 1;
        #1 outs("br_pend_flush", FL);
        @(negedge clk); clr();
        #1 outs("br_after", NONE);
        cnts("br_imem", 7, 1);
        @(negedge clk); lw_use(); b.br_taken = 1;
        #1 outs("br_over_lu", FL);
        @(negedge clk); clr();
        #1 outs("br_over_lu_after", NONE);
        cnts("br_over_lu", 7, 2);
        @(negedge clk); b.dmem_req = 1;
        #1 outs("sat_w1", ALL);
        @(negedge clk); #1 outs("sat_w2", ALL);
        @(negedge clk); b.dmem_resp = 1;
        #1 outs("sat_resp", NONE);
        @(negedge clk); clr();
        #1 cnts("sat", 7, 2);
        b.dmem_req = 1;
        #1 outs("mw_lu_w", ALL);
        @(negedge clk); b.dmem_resp = 1; lw_use();
        #1 outs("mw_exit_lu", LU);
        @(negedge clk); b.dmem_resp = 0;
        #1 outs("lub_to_mw", ALL);
        @(negedge clk); clr(); b.dmem_req = 1; b.dmem_resp = 1;
        #1 outs("lub_mw_exit", NONE);
        @(negedge clk); clr(); b.imem_read = 1; b.br_taken = 1;
        #1 outs("rst_pre_w1", ALL);
        @(negedge clk); #1 outs("rst_pre_w2", ALL);
        #1 rst = 0;
        #1 outs("rst_mid_stall", NONE);
        cnts("rst_mid", 0, 0);
        @(negedge clk); #1 outs("rst_held", NONE);
        @(negedge clk); clr(); rst = 1;
        #1 outs("rst_release", NONE);
        @(negedge clk); b.dmem_req = 1;
        #1 outs("post_rst_w", ALL);
        @(negedge clk); b.dmem_resp = 1;
        #1 outs("post_rst_no_flush", NONE);
        @(negedge clk); clr();
        #1 cnts("post_rst", 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
